// File: rtl/eth_tx_arbiter.sv
// Round-robin transmit arbiter for ARP/ICMP/UDP reply frames.
// One pending bit per source, START/BUSY/GAP sequencing with BUSY timeout.
module eth_tx_arbiter #(
   parameter int IFG_CYCLES     = 12,
   parameter int TIMEOUT_CYCLES = 2048
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_arp_req,
   input  logic       i_icmp_req,
   input  logic       i_udp_req,
   input  logic       i_tx_done,
   output logic       o_tx_start,
   output logic [1:0] o_tx_sel,
   output logic       o_busy,
   output logic       o_timeout,
   output logic [7:0] o_drop_cnt
);

   localparam int MAXC = (IFG_CYCLES > TIMEOUT_CYCLES) ? IFG_CYCLES : TIMEOUT_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] C_TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] C_IFG_LAST = CW'(IFG_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_BUSY  = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   localparam logic [1:0] SEL_ARP  = 2'd1;
   localparam logic [1:0] SEL_ICMP = 2'd2;
   localparam logic [1:0] SEL_UDP  = 2'd3;

   logic [1:0]    r_state;
   logic [2:0]    r_pend;     // bit0 ARP, bit1 ICMP, bit2 UDP
   logic [1:0]    r_last;
   logic [1:0]    r_win;
   logic [CW-1:0] r_cnt;
   logic          r_timeout;
   logic [7:0]    r_drop;

   logic [2:0] w_req;
   logic [1:0] w_win;
   logic       w_grant;
   logic [2:0] w_clr;
   logic [2:0] w_drop;
   logic [1:0] w_ndrop;
   logic [8:0] w_dsum;

   assign w_req = {i_udp_req, i_icmp_req, i_arp_req};

   // Search starts at the source after the last granted one.
   always_comb begin
      w_win = 2'd0;
      case (r_last)
         SEL_ARP: begin
            if      (r_pend[1]) w_win = SEL_ICMP;
            else if (r_pend[2]) w_win = SEL_UDP;
            else if (r_pend[0]) w_win = SEL_ARP;
         end
         SEL_ICMP: begin
            if      (r_pend[2]) w_win = SEL_UDP;
            else if (r_pend[0]) w_win = SEL_ARP;
            else if (r_pend[1]) w_win = SEL_ICMP;
         end
         default: begin
            if      (r_pend[0]) w_win = SEL_ARP;
            else if (r_pend[1]) w_win = SEL_ICMP;
            else if (r_pend[2]) w_win = SEL_UDP;
         end
      endcase
   end

   assign w_grant = (r_state == S_IDLE) && (|r_pend);

   always_comb begin
      w_clr = 3'b000;
      if (w_grant) begin
         case (w_win)
            SEL_ARP:  w_clr = 3'b001;
            SEL_ICMP: w_clr = 3'b010;
            SEL_UDP:  w_clr = 3'b100;
            default:  w_clr = 3'b000;
         endcase
      end
   end

   // A request landing on its own grant cycle is a fresh request, not a drop.
   assign w_drop  = w_req & r_pend & ~w_clr;
   assign w_ndrop = 2'(w_drop[0]) + 2'(w_drop[1]) + 2'(w_drop[2]);
   assign w_dsum  = {1'b0, r_drop} + {7'b0, w_ndrop};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pend <= 3'b000;
         r_drop <= 8'd0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_req;
         r_drop <= w_dsum[8] ? 8'hFF : w_dsum[7:0];
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_last    <= SEL_UDP;
         r_win     <= 2'd0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_state <= S_START;
                  r_win   <= w_win;
                  r_last  <= w_win;
               end
            end
            S_START: begin
               r_state <= S_BUSY;
               r_cnt   <= '0;
            end
            S_BUSY: begin
               if (i_tx_done) begin
                  r_state <= S_GAP;
                  r_cnt   <= '0;
               end else if (r_cnt == C_TO_LAST) begin
                  r_state   <= S_GAP;
                  r_cnt     <= '0;
                  r_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               if (r_cnt == C_IFG_LAST) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_win   <= 2'd0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign o_tx_start = (r_state == S_START);
   assign o_tx_sel   = ((r_state == S_START) || (r_state == S_BUSY)) ? r_win : 2'd0;
   assign o_busy     = (r_state != S_IDLE);
   assign o_timeout  = r_timeout;
   assign o_drop_cnt = r_drop;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: expected grants queued at request
// time, popped on each o_tx_start; timing and counters checked inline.
module tb_eth_tx_arbiter;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_arp_req = 1'b0;
   logic       i_icmp_req = 1'b0;
   logic       i_udp_req = 1'b0;
   logic       i_tx_done = 1'b0;
   logic       o_tx_start;
   logic [1:0] o_tx_sel;
   logic       o_busy;
   logic       o_timeout;
   logic [7:0] o_drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;
   logic [1:0] exp_q[$];

   eth_tx_arbiter #(.IFG_CYCLES(12), .TIMEOUT_CYCLES(2048)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_arp_req(i_arp_req), .i_icmp_req(i_icmp_req), .i_udp_req(i_udp_req),
      .i_tx_done(i_tx_done),
      .o_tx_start(o_tx_start), .o_tx_sel(o_tx_sel), .o_busy(o_busy),
      .o_timeout(o_timeout), .o_drop_cnt(o_drop_cnt)
   );

   always #5 i_clk = ~i_clk;

   // cycle 0 is the cycle in which reset is released
   always @(posedge i_clk or posedge i_reset)
      if (i_reset) cyc <= 0;
      else         cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge i_clk) begin
      if (!i_reset && o_tx_start) begin
         if (exp_q.size() == 0) chk("unexpected_start_qsize", exp_q.size(), 1);
         else chk("grant_sel", int'(o_tx_sel), int'(exp_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      {i_arp_req, i_icmp_req, i_udp_req, i_tx_done} = 4'b0;
      exp_q.delete();
      tick();
      tick();
      i_reset = 1'b0;
   endtask

   // mask bit0 ARP, bit1 ICMP, bit2 UDP, bit3 done
   task automatic pulse(input logic [3:0] m);
      {i_tx_done, i_udp_req, i_icmp_req, i_arp_req} = m;
      tick();
      {i_tx_done, i_udp_req, i_icmp_req, i_arp_req} = 4'b0;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) tick();
   endtask

   task automatic wait_start(output int s);
      s = -1;
      for (int i = 0; i < 100; i++) begin
         if (o_tx_start) begin s = cyc; break; end
         tick();
      end
      if (s < 0) chk("start_wait", int'(o_tx_start), 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && o_busy; i++) tick();
      chk("idle_wait", int'(o_busy), 0);
   endtask

   // serve n frames: done pulse shortly after each start
   task automatic serve(input int n, output int starts[4], output int dones[4]);
      int s;
      for (int k = 0; k < n; k++) begin
         wait_start(s);
         starts[k] = s;
         tick();
         tick();
         dones[k] = cyc;
         pulse(4'b1000);
      end
      wait_idle();
   endtask

   // run a frame with no done (or done at a chosen offset) across the timeout
   task automatic run_timeout(input int s, input int done_off,
                              output int to_n, output int to_c,
                              output int b60, output int b61, output int gsel);
      to_n = 0; to_c = -1; b60 = -1; b61 = -1; gsel = -1;
      while (cyc < s + 2065) begin
         if (o_timeout) begin to_n++; to_c = cyc; end
         if (cyc == s + 2055) gsel = int'(o_tx_sel);
         if (cyc == s + 2060) b60 = int'(o_busy);
         if (cyc == s + 2061) b61 = int'(o_busy);
         i_tx_done = (cyc == s + done_off);
         tick();
      end
      i_tx_done = 1'b0;
   endtask

   initial begin
      int s, to_n, to_c, b60, b61, gsel;
      int st[4], dn[4];

      // reset state
      tick();
      chk("rst_start", int'(o_tx_start), 0);
      chk("rst_sel", int'(o_tx_sel), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_timeout", int'(o_timeout), 0);
      chk("rst_drop", int'(o_drop_cnt), 0);
      do_reset();

      // single ARP: req cycle 10 -> start 12, done 20 -> busy low at 33
      wait_cyc(10);
      exp_q.push_back(2'b01);
      pulse(4'b0001);
      chk("arp_no_start_11", int'(o_tx_start), 0);
      tick();
      chk("arp_start_cyc12", int'(o_tx_start), 1);
      chk("arp_sel_cyc12", int'(o_tx_sel), 1);
      wait_cyc(20);
      pulse(4'b1000);
      chk("arp_gap_sel", int'(o_tx_sel), 0);
      wait_cyc(32);
      chk("arp_busy_cyc32", int'(o_busy), 1);
      tick();
      chk("arp_busy_cyc33", int'(o_busy), 0);

      // three simultaneous requests after reset -> 01,10,11
      do_reset();
      exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b11);
      pulse(4'b0111);
      serve(3, st, dn);
      chk("rr3_gap1", st[1] - dn[0], 14);
      chk("rr3_gap2", st[2] - dn[1], 14);
      chk("rr3_drop", int'(o_drop_cnt), 0);

      // ICMP granted, then ICMP+ARP during BUSY -> ARP then ICMP
      do_reset();
      exp_q.push_back(2'b10);
      pulse(4'b0010);
      wait_start(s);
      tick();
      exp_q.push_back(2'b01); exp_q.push_back(2'b10);
      pulse(4'b0011);
      pulse(4'b0010);
      chk("rr_drop_one", int'(o_drop_cnt), 1);
      pulse(4'b1000);
      serve(2, st, dn);

      // re-request on grant cycle retained, others dropped (+2 at once)
      do_reset();
      exp_q.push_back(2'b01); exp_q.push_back(2'b10);
      exp_q.push_back(2'b11); exp_q.push_back(2'b01);
      pulse(4'b0111);
      pulse(4'b0111);
      chk("multi_drop", int'(o_drop_cnt), 2);
      serve(4, st, dn);

      // timeout with done pulse in GAP ignored
      do_reset();
      exp_q.push_back(2'b11);
      pulse(4'b0100);
      wait_start(s);
      run_timeout(s, 2052, to_n, to_c, b60, b61, gsel);
      chk("to_count", to_n, 1);
      chk("to_cycle", to_c - s, 2049);
      chk("to_gap_sel", gsel, 0);
      chk("to_busy_end_gap", b60, 1);
      chk("to_idle_after_gap", b61, 0);

      // done on the final BUSY cycle wins over timeout
      do_reset();
      exp_q.push_back(2'b01);
      pulse(4'b0001);
      wait_start(s);
      run_timeout(s, 2048, to_n, to_c, b60, b61, gsel);
      chk("to_prio_none", to_n, 0);
      chk("to_prio_idle", b61, 0);

      // drop counter saturation, then reset mid-BUSY
      do_reset();
      exp_q.push_back(2'b01);
      pulse(4'b0001);
      wait_start(s);
      tick();
      exp_q.push_back(2'b11);
      for (int k = 0; k < 300; k++) begin
         pulse(4'b0100);
         if (k == 9) chk("drop_partial", int'(o_drop_cnt), 9);
      end
      chk("drop_sat", int'(o_drop_cnt), 255);
      pulse(4'b1000);
      wait_start(s);
      tick();
      tick();
      chk("mid_busy_sel", int'(o_tx_sel), 3);
      i_reset = 1'b1;
      #1;
      chk("rst_async_busy", int'(o_busy), 0);
      chk("rst_async_sel", int'(o_tx_sel), 0);
      chk("rst_async_drop", int'(o_drop_cnt), 0);
      do_reset();
      for (int k = 0; k < 40; k++) tick();
      chk("post_rst_idle", int'(o_busy), 0);
      chk("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12, inter-frame gap length in clock cycles (min 1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2048, maximum BUSY duration in cycles before forced abort (min 2).
REQ-003 SHALL have i_clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have i_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have i_arp_req  input  1  1-clk pulse: ARP reply frame requested.
REQ-006 SHALL have i_icmp_req  input  1  1-clk pulse: ICMP echo reply frame requested.
REQ-007 SHALL have i_udp_req  input  1  1-clk pulse: UDP frame requested.
REQ-008 SHALL have i_tx_done  input  1  1-clk pulse from byte-serial transmitter: frame (incl. CRC) sent.
REQ-009 SHALL have o_tx_start  output  1  1-clk pulse: transmitter starts frame of type o_tx_sel.
REQ-010 SHALL have o_tx_sel  output  2  granted source: 00 none, 01 ARP, 10 ICMP, 11 UDP.
REQ-011 SHALL have o_busy  output  1  high while in START, BUSY or GAP.
REQ-012 SHALL have o_timeout  output  1  1-clk pulse: BUSY aborted, no i_tx_done.
REQ-013 SHALL have o_drop_cnt  output  8  saturating count of requests arriving while same source already pending.

Function
REQ-014 SHALL keep one pending bit per source; set on its req pulse, cleared on the cycle the source enters START.
REQ-015 Req pulse on the same cycle its pending bit is cleared by grant SHALL leave the bit set (new request retained, no drop).
REQ-016 Req pulse while its pending bit is set and not being cleared SHALL increment o_drop_cnt by 1, saturating at 255; simultaneous drops on several sources SHALL add each (saturating).
REQ-017 FSM states: IDLE, START, BUSY, GAP.
REQ-018 IDLE: if any pending bit set (registered value), next state START with winner chosen by round-robin; else stay IDLE.
REQ-019 Round-robin order ARP->ICMP->UDP->ARP; search begins at source after last granted; after reset last granted = UDP (ARP first).
REQ-020 START lasts exactly 1 cycle: o_tx_start=1, o_tx_sel=winner; next state BUSY.
REQ-021 Request pulse in cycle N with FSM in IDLE SHALL produce o_tx_start in cycle N+2 (pending registered N+1, START N+2).
REQ-022 o_tx_sel SHALL hold winner through START and BUSY; 00 in IDLE and GAP.
REQ-023 BUSY: cycle counter from 0; i_tx_done=1 -> GAP; else counter reaching TIMEOUT_CYCLES-1 -> o_timeout pulse on that cycle's next edge output, state GAP.
REQ-024 i_tx_done coincident with timeout cycle SHALL take priority: no o_timeout.
REQ-025 i_tx_done outside BUSY (incl. START) SHALL be ignored.
REQ-026 GAP lasts exactly IFG_CYCLES cycles, then IDLE; requests during START/BUSY/GAP only set pending bits.
REQ-027 Counters SHALL be sized ceil(log2(max(IFG_CYCLES,TIMEOUT_CYCLES)))+1 bits; no wrap within a state.

Reset
REQ-028 i_reset=1 SHALL asynchronously force: state IDLE, pending bits 0, counters 0, RR pointer = UDP, o_tx_start=0, o_tx_sel=00, o_busy=0, o_timeout=0, o_drop_cnt=0.
REQ-029 Reset mid-frame SHALL discard grant and all pending requests; first edge after release evaluates IDLE with nothing pending.

Verification
REQ-030 Single ARP req at cycle 10 -> o_tx_start=1, o_tx_sel=01 at cycle 12; i_tx_done at 20 -> o_busy low at cycle 21+IFG_CYCLES (=33 with 12).
REQ-031 ARP, ICMP, UDP pulsed same cycle -> three frames granted in order 01, 10, 11, each separated by done + 12-cycle gap; o_drop_cnt=0.
REQ-032 After ICMP grant, ICMP and ARP requested again during BUSY -> next grant UDP-skipped order: ARP (01) then ICMP (10) per round-robin from last=ICMP.
REQ-033 Grant, no i_tx_done -> o_timeout pulse after 2048 BUSY cycles, GAP 12 cycles, IDLE; done pulse in GAP ignored.
REQ-034 UDP pulsed 300 times while BUSY -> o_drop_cnt=255 (saturated), single UDP grant follows; i_reset mid-BUSY -> all outputs zero immediately, no further grant.
